// File: rtl/ex_stage.sv
// Execute stage of a 5-stage RV32 pipeline. Owns the EX/MEM register.
// Single-cycle ALU for codes 0-10, iterative restoring divider for 11-14.
// Divides by zero and the signed overflow case complete in one cycle.
module ex_stage #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [1:0]      wb_ctl,
    input  logic [2:0]      m_ctl,
    input  logic            alusrc,
    input  logic [4:0]      alu_ctl,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    output logic            ex_stall,
    output logic [1:0]      wb_ctlout,
    output logic            branch,
    output logic            memread,
    output logic            memwrite,
    output logic            zero,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] rdata2out,
    output logic [4:0]      five_bit_muxout
);

    localparam int STEPS = XLEN / DIV_BITS;
    localparam int CW    = $clog2(STEPS + 1);
    localparam int SW    = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST  = CW'(STEPS - 1);
    localparam logic [XLEN-1:0] ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MINV  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZEROV = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d, rem_sel_q, rem_sel_d;
    logic [1:0]      hwb_q, hwb_d;
    logic [2:0]      hm_q, hm_d;
    logic [4:0]      hrd_q, hrd_d;
    logic [XLEN-1:0] hst_q, hst_d;
    logic [1:0]      wb_ctlout_q, wb_ctlout_d;
    logic [2:0]      m_out_q, m_out_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d, rdata2out_q, rdata2out_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic [XLEN-1:0] op_b_s, alu_res_s, abs_a_s, abs_b_s, done_res_s;
    logic [XLEN-1:0] step_quo_s, step_rem_s;
    logic [XLEN:0]   rem_t_s;
    logic            is_div_s, signed_op_s, div_zero_s, div_ovf_s, accept_s;
    logic            a_neg_s, b_neg_s;

    assign op_b_s      = alusrc ? imm : rdata2;
    assign is_div_s    = (alu_ctl >= 5'd11) && (alu_ctl <= 5'd14);
    assign signed_op_s = (alu_ctl == 5'd11) || (alu_ctl == 5'd13);
    assign div_zero_s  = (op_b_s == ZEROV);
    assign div_ovf_s   = signed_op_s && (rdata1 == MINV) && (op_b_s == ONES);
    assign a_neg_s     = signed_op_s && rdata1[XLEN-1];
    assign b_neg_s     = signed_op_s && op_b_s[XLEN-1];
    assign abs_a_s     = a_neg_s ? (ZEROV - rdata1) : rdata1;
    assign abs_b_s     = b_neg_s ? (ZEROV - op_b_s) : op_b_s;
    // Only a regular divide (not zero divisor, not overflow) enters the FSM.
    assign accept_s    = (state_q == S_IDLE) && id_valid && is_div_s && !flush
                         && !div_zero_s && !div_ovf_s;

    // Single-cycle ALU result, including the special-case divides.
    always_comb begin
        alu_res_s = ZEROV;
        case (alu_ctl)
            5'd0:    alu_res_s = rdata1 + op_b_s;
            5'd1:    alu_res_s = rdata1 - op_b_s;
            5'd2:    alu_res_s = rdata1 & op_b_s;
            5'd3:    alu_res_s = rdata1 | op_b_s;
            5'd4:    alu_res_s = rdata1 ^ op_b_s;
            5'd5:    alu_res_s = rdata1 << op_b_s[SW-1:0];
            5'd6:    alu_res_s = rdata1 >> op_b_s[SW-1:0];
            5'd7:    alu_res_s = $unsigned($signed(rdata1) >>> op_b_s[SW-1:0]);
            5'd8:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(op_b_s))};
            5'd9:    alu_res_s = {{(XLEN-1){1'b0}}, (rdata1 < op_b_s)};
            5'd10:   alu_res_s = rdata1 * op_b_s;
            5'd11:   alu_res_s = div_zero_s ? ONES : (div_ovf_s ? MINV : ZEROV);
            5'd12:   alu_res_s = div_zero_s ? ONES : ZEROV;
            5'd13:   alu_res_s = div_zero_s ? rdata1 : ZEROV;
            5'd14:   alu_res_s = div_zero_s ? rdata1 : ZEROV;
            default: alu_res_s = ZEROV;
        endcase
    end

    // One restoring-division step retiring DIV_BITS quotient bits.
    always_comb begin
        rem_t_s    = {1'b0, rem_q};
        step_quo_s = quo_q;
        for (int i = 0; i < DIV_BITS; i++) begin
            rem_t_s    = {rem_t_s[XLEN-1:0], step_quo_s[XLEN-1]};
            step_quo_s = {step_quo_s[XLEN-2:0], 1'b0};
            if (rem_t_s >= {1'b0, dvs_q}) begin
                rem_t_s       = rem_t_s - {1'b0, dvs_q};
                step_quo_s[0] = 1'b1;
            end else begin
                step_quo_s[0] = 1'b0;
            end
        end
        step_rem_s = rem_t_s[XLEN-1:0];
    end

    // Sign fix-up of the finished division and quotient/remainder select.
    always_comb begin
        if (rem_sel_q) begin
            done_res_s = r_neg_q ? (ZEROV - rem_q) : rem_q;
        end else begin
            done_res_s = q_neg_q ? (ZEROV - quo_q) : quo_q;
        end
    end

    // Divider FSM next state: flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = accept_s ? S_DIV : S_IDLE;
                S_DIV:   state_d = (cnt_q == LAST) ? S_DONE : S_DIV;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stall output: high on acceptance and through every divide step.
    always_comb begin
        ex_stall = accept_s || (state_q == S_DIV);
    end

    // Divider datapath and EX/MEM register next values (bubble by default).
    always_comb begin
        cnt_d = cnt_q;  rem_d = rem_q;  quo_d = quo_q;  dvs_d = dvs_q;
        q_neg_d = q_neg_q;  r_neg_d = r_neg_q;  rem_sel_d = rem_sel_q;
        hwb_d = hwb_q;  hm_d = hm_q;  hrd_d = hrd_q;  hst_d = hst_q;
        wb_ctlout_d  = 2'b00;
        m_out_d      = 3'b000;
        alu_result_d = ZEROV;
        zero_d       = 1'b1;
        rdata2out_d  = rdata2;
        rd_out_d     = rd;
        if (flush) begin
            cnt_d = {CW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        cnt_d     = {CW{1'b0}};
                        rem_d     = ZEROV;
                        quo_d     = abs_a_s;
                        dvs_d     = abs_b_s;
                        q_neg_d   = a_neg_s ^ b_neg_s;
                        r_neg_d   = a_neg_s;
                        rem_sel_d = (alu_ctl == 5'd13) || (alu_ctl == 5'd14);
                        hwb_d     = wb_ctl;
                        hm_d      = m_ctl;
                        hrd_d     = rd;
                        hst_d     = rdata2;
                    end else if (id_valid) begin
                        wb_ctlout_d  = wb_ctl;
                        m_out_d      = m_ctl;
                        alu_result_d = alu_res_s;
                        zero_d       = (alu_res_s == ZEROV);
                    end else begin
                        zero_d = 1'b1;
                    end
                end
                S_DIV: begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + CW'(1);
                end
                S_DONE: begin
                    wb_ctlout_d  = hwb_q;
                    m_out_d      = hm_q;
                    alu_result_d = done_res_s;
                    zero_d       = (done_res_s == ZEROV);
                    rdata2out_d  = hst_q;
                    rd_out_d     = hrd_q;
                end
                default: begin
                    cnt_d = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, divider and EX/MEM registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;  cnt_q <= {CW{1'b0}};
            rem_q <= ZEROV;  quo_q <= ZEROV;  dvs_q <= ZEROV;
            q_neg_q <= 1'b0;  r_neg_q <= 1'b0;  rem_sel_q <= 1'b0;
            hwb_q <= 2'b00;  hm_q <= 3'b000;  hrd_q <= 5'd0;  hst_q <= ZEROV;
            wb_ctlout_q <= 2'b00;  m_out_q <= 3'b000;  zero_q <= 1'b0;
            alu_result_q <= ZEROV;  rdata2out_q <= ZEROV;  rd_out_q <= 5'd0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;
            rem_q <= rem_d;  quo_q <= quo_d;  dvs_q <= dvs_d;
            q_neg_q <= q_neg_d;  r_neg_q <= r_neg_d;  rem_sel_q <= rem_sel_d;
            hwb_q <= hwb_d;  hm_q <= hm_d;  hrd_q <= hrd_d;  hst_q <= hst_d;
            wb_ctlout_q <= wb_ctlout_d;  m_out_q <= m_out_d;  zero_q <= zero_d;
            alu_result_q <= alu_result_d;  rdata2out_q <= rdata2out_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign wb_ctlout       = wb_ctlout_q;
    assign branch          = m_out_q[2];
    assign memread         = m_out_q[1];
    assign memwrite        = m_out_q[0];
    assign zero            = zero_q;
    assign alu_result      = alu_result_q;
    assign rdata2out       = rdata2out_q;
    assign five_bit_muxout = rd_out_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage (XLEN=32, DIV_BITS=1).
module tb_ex_stage;

    logic        clock, reset, flush, id_valid, alusrc;
    logic [1:0]  wb_ctl;
    logic [2:0]  m_ctl;
    logic [4:0]  alu_ctl, rd;
    logic [31:0] rdata1, rdata2, imm;
    logic        ex_stall, branch, memread, memwrite, zero;
    logic [1:0]  wb_ctlout;
    logic [31:0] alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;

    int err_cnt = 0;
    int chk_cnt = 0;

    ex_stage #(.XLEN(32), .DIV_BITS(1)) dut (
        .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .alusrc(alusrc), .alu_ctl(alu_ctl),
        .rdata1(rdata1), .rdata2(rdata2), .imm(imm), .rd(rd),
        .ex_stall(ex_stall), .wb_ctlout(wb_ctlout), .branch(branch),
        .memread(memread), .memwrite(memwrite), .zero(zero),
        .alu_result(alu_result), .rdata2out(rdata2out),
        .five_bit_muxout(five_bit_muxout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic src, input logic [31:0] im,
                          input logic [1:0] wb, input logic [2:0] m, input logic [4:0] r);
        id_valid = v; alu_ctl = ctl; rdata1 = a; rdata2 = b; alusrc = src;
        imm = im; wb_ctl = wb; m_ctl = m; rd = r;
    endtask

    // single-cycle op: no stall, result and zero flag after one edge
    task automatic alu_op(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic src, input logic [31:0] im,
                          input logic [31:0] exp);
        set_in(1'b1, ctl, a, b, src, im, 2'b10, 3'b000, 5'd7);
        #1;
        chk({tag, "_stall"}, {31'd0, ex_stall}, 32'd0);
        step();
        chk(tag, alu_result, exp);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    endtask

    // divide: count stall cycles (bounded), check bubbles, return result
    task automatic do_div(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int stalls);
        bit done;
        set_in(1'b1, ctl, a, b, 1'b0, 32'd0, 2'b11, 3'b010, 5'd9);
        #1;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ex_stall !== 1'b1) begin
                done = 1'b1;
                break;
            end
            stalls++;
            step();
            if (stalls == 1 || stalls == 20) chk({tag, "_bubble_wb"}, {30'd0, wb_ctlout}, 32'd0);
        end
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
        step();
        res = alu_result;
        chk({tag, "_wb"}, {30'd0, wb_ctlout}, 32'd3);
        chk({tag, "_rd"}, {27'd0, five_bit_muxout}, 32'd9);
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00, 3'b000, 5'd0);
    endtask

    logic [31:0] res;
    int stalls;

    initial begin
        reset = 1'b1; flush = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00, 3'b000, 5'd0);
        step(); step();
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_wb", {30'd0, wb_ctlout}, 32'd0);
        chk("rst_stall", {31'd0, ex_stall}, 32'd0);
        reset = 1'b0;
        step();
        chk("bubble_zero", {31'd0, zero}, 32'd1);
        chk("bubble_alu", alu_result, 32'd0);

        // ADD 7 + (-3)
        set_in(1'b1, 5'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'd100, 2'b10, 3'b000, 5'd3);
        #1;
        chk("add_stall", {31'd0, ex_stall}, 32'd0);
        step();
        chk("add", alu_result, 32'd4);
        chk("add_zero", {31'd0, zero}, 32'd0);
        chk("add_wb", {30'd0, wb_ctlout}, 32'd2);
        chk("add_rd", {27'd0, five_bit_muxout}, 32'd3);
        chk("add_st", rdata2out, 32'hFFFF_FFFD);

        // SUB 5 - 5 with branch
        set_in(1'b1, 5'd1, 32'd5, 32'd5, 1'b0, 32'd0, 2'b00, 3'b100, 5'd0);
        step();
        chk("sub", alu_result, 32'd0);
        chk("sub_zero", {31'd0, zero}, 32'd1);
        chk("sub_branch", {31'd0, branch}, 32'd1);

        alu_op("and",  5'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'd0, 32'h00F0_1234);
        alu_op("or",   5'd3,  32'h0000_00F0, 32'd0, 1'b1, 32'h0000_000F, 32'h0000_00FF);
        alu_op("xor",  5'd4,  32'hFFFF_0000, 32'hFF00_FF00, 1'b0, 32'd0, 32'h00FF_FF00);
        alu_op("sll",  5'd5,  32'h0000_0001, 32'd0, 1'b1, 32'h0000_0024, 32'h0000_0010);
        alu_op("srl",  5'd6,  32'h8000_0000, 32'd31, 1'b0, 32'd0, 32'h0000_0001);
        alu_op("sra",  5'd7,  32'h8000_0000, 32'd4, 1'b0, 32'd0, 32'hF800_0000);
        alu_op("slt",  5'd8,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd1);
        alu_op("sltu", 5'd9,  32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
        alu_op("mul",  5'd10, 32'd6, 32'hFFFF_FFF9, 1'b0, 32'd0, 32'hFFFF_FFD6);
        alu_op("ovfadd", 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
        alu_op("code20", 5'd20, 32'd5, 32'd3, 1'b0, 32'd0, 32'd0);

        do_div("div_m7_2", 5'd11, 32'hFFFF_FFF9, 32'd2, res, stalls);
        chk("div_m7_2", res, 32'hFFFF_FFFD);
        chk("div_m7_2_stalls", stalls, 32'd33);
        do_div("rem_m7_2", 5'd13, 32'hFFFF_FFF9, 32'd2, res, stalls);
        chk("rem_m7_2", res, 32'hFFFF_FFFF);
        do_div("div_7_m2", 5'd11, 32'd7, 32'hFFFF_FFFE, res, stalls);
        chk("div_7_m2", res, 32'hFFFF_FFFD);
        do_div("rem_7_m2", 5'd13, 32'd7, 32'hFFFF_FFFE, res, stalls);
        chk("rem_7_m2", res, 32'd1);
        do_div("divu_big", 5'd12, 32'hFFFF_FFFF, 32'd16, res, stalls);
        chk("divu_big", res, 32'h0FFF_FFFF);
        do_div("remu_big", 5'd14, 32'hFFFF_FFFF, 32'd16, res, stalls);
        chk("remu_big", res, 32'd15);
        do_div("divu_z", 5'd12, 32'd100, 32'd0, res, stalls);
        chk("divu_z", res, 32'hFFFF_FFFF);
        chk("divu_z_stalls", stalls, 32'd0);
        do_div("remu_z", 5'd14, 32'd100, 32'd0, res, stalls);
        chk("remu_z", res, 32'd100);
        do_div("rem_ovf", 5'd13, 32'h8000_0000, 32'hFFFF_FFFF, res, stalls);
        chk("rem_ovf", res, 32'd0);
        chk("rem_ovf_stalls", stalls, 32'd0);
        do_div("div_ovf", 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, res, stalls);
        chk("div_ovf", res, 32'h8000_0000);

        // flush at divide step 10
        set_in(1'b1, 5'd11, 32'd100, 32'd7, 1'b0, 32'd0, 2'b10, 3'b000, 5'd4);
        step();
        for (int i = 0; i < 10; i++) step();
        chk("fl_stall_before", {31'd0, ex_stall}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00, 3'b000, 5'd0);
        #1;
        chk("fl_stall", {31'd0, ex_stall}, 32'd0);
        chk("fl_wb", {30'd0, wb_ctlout}, 32'd0);
        chk("fl_alu", alu_result, 32'd0);
        alu_op("fl_add", 5'd0, 32'd1, 32'd2, 1'b0, 32'd0, 32'd3);

        // flush together with divide acceptance: not started
        set_in(1'b1, 5'd12, 32'd50, 32'd5, 1'b0, 32'd0, 2'b10, 3'b000, 5'd4);
        flush = 1'b1;
        #1;
        chk("flacc_stall", {31'd0, ex_stall}, 32'd0);
        step();
        flush = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00, 3'b000, 5'd0);
        #1;
        chk("flacc_stall2", {31'd0, ex_stall}, 32'd0);

        // reset at divide step 5
        set_in(1'b1, 5'd11, 32'd1000, 32'd3, 1'b0, 32'd0, 2'b10, 3'b000, 5'd4);
        step();
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 2'b00, 3'b000, 5'd0);
        step();
        chk("rd_stall", {31'd0, ex_stall}, 32'd0);
        chk("rd_alu", alu_result, 32'd0);
        chk("rd_zero", {31'd0, zero}, 32'd0);
        reset = 1'b0;
        step();
        chk("rd_idle_stall", {31'd0, ex_stall}, 32'd0);
        do_div("divu_9_3", 5'd12, 32'd9, 32'd3, res, stalls);
        chk("divu_9_3", res, 32'd3);
        chk("divu_9_3_stalls", stalls, 32'd33);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
